// File: rtl/led_fb_pkg.sv
// led_fb_pkg: shared defaults, commit FSM encoding and bank/address packing for the frame buffer arbiter
package led_fb_pkg;
  localparam int NUM_STRIPS_DEF = 2;
  localparam int ADDRESS_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} commit_state_t;
  function automatic logic [31:0] bank_addr(input logic bank, input logic [31:0] addr, input int unsigned aw);
    return (32'(bank) << aw) | addr;
  endfunction
endpackage

// File: rtl/frame_buffer_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, with the pointer to use next
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);
  logic          found;
  logic [PW-1:0] idx;
  // scan requests from ptr upward, wrapping, and take the first one set
  always_comb begin
    gnt = '0;
    next_ptr = ptr;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PW'((int'(idx) + 1) % N);
      end
    end
  end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares a double-banked frame RAM between one writer and several strip readers
module frame_buffer_arbiter import led_fb_pkg::*; #(
  parameter int NUM_STRIPS = NUM_STRIPS_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             wr_en,
  input  logic [ADDRESS_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             commit,
  output logic                             commit_pending,
  output logic                             swapped,
  output logic                             bank_sel,
  input  logic [NUM_STRIPS-1:0]            frame_busy,
  input  logic [NUM_STRIPS-1:0]            rd_req,
  input  logic [NUM_STRIPS*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_STRIPS-1:0]            rd_gnt,
  output logic [NUM_STRIPS-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             ram_we,
  output logic [ADDRESS_WIDTH:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);
  localparam int PW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            next_ptr;
  logic [NUM_STRIPS-1:0]    arb_gnt;
  logic [NUM_STRIPS-1:0]    gnt_d;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  commit_state_t            state;
  rr_arbiter #(.N(NUM_STRIPS), .PW(PW)) u_arb (
    .req(rd_req),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .next_ptr(next_ptr)
  );
  assign rd_gnt = (resetn && !wr_en) ? arb_gnt : '0;
  assign rd_data = ram_rdata;
  assign commit_pending = (state == PENDING);
  // route the granted strip's address to the RAM port
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_STRIPS; i++) sel_addr = arb_gnt[i] ? rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] : sel_addr;
  end
  // RAM port register: writes to the back bank win, otherwise the granted read hits the front bank
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      rr_ptr <= '0;
    end else if (wr_en) begin
      ram_we <= 1'b1;
      ram_addr <= (ADDRESS_WIDTH+1)'(bank_addr(~bank_sel, 32'(wr_addr), ADDRESS_WIDTH));
      ram_wdata <= wr_data;
    end else begin
      ram_we <= 1'b0;
      if (|arb_gnt) begin
        ram_addr <= (ADDRESS_WIDTH+1)'(bank_addr(bank_sel, 32'(sel_addr), ADDRESS_WIDTH));
        rr_ptr <= next_ptr;
      end
    end
  end
  // read valid trails the grant by the address cycle plus the RAM's registered read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_d <= '0;
      rd_valid <= '0;
    end else begin
      gnt_d <= rd_gnt;
      rd_valid <= gnt_d;
    end
  end
  // commit FSM: swap banks only when no strip is mid-frame and the port is not being written
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      bank_sel <= 1'b0;
      swapped <= 1'b0;
    end else begin
      swapped <= 1'b0;
      if (state == IDLE) state <= commit ? PENDING : IDLE;
      else if (frame_busy == '0 && !wr_en) begin
        bank_sel <= ~bank_sel;
        swapped <= 1'b1;
        state <= commit ? PENDING : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: randomized bench against a behavioural bank/arbitration model
module tb_frame_buffer_arbiter;
  localparam int N = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  logic            clk = 1'b0;
  logic            resetn;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            commit;
  logic            commit_pending;
  logic            swapped;
  logic            bank_sel;
  logic [N-1:0]    frame_busy;
  logic [N-1:0]    rd_req;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_gnt;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            ram_we;
  logic [AW:0]     ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata = '0;
  frame_buffer_arbiter #(.NUM_STRIPS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending), .swapped(swapped), .bank_sel(bank_sel),
    .frame_busy(frame_busy), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #10 clk = ~clk;
  logic [DW-1:0] phys [512];
  always @(posedge clk) begin
    if (ram_we) phys[ram_addr] <= ram_wdata;
    ram_rdata <= phys[ram_addr];
  end
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] mem [2][256];
  int            m_bank, m_ptr;
  bit            m_pend, e_we, e_sw;
  logic [AW:0]   e_addr;
  logic [DW-1:0] e_wdata, d1, d2;
  logic [N-1:0]  e_v1, e_v2, last_g;
  logic [N-1:0]  req_s;
  logic [AW-1:0] addr_s [N];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return N'(1 << ((p + k) % N));
    return '0;
  endfunction
  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    wr_en = 1'b1;
    rd_req = '1;
    commit = 1'b1;
    frame_busy = '0;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_gnt", rd_gnt, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_swapped", swapped, 0);
      chk("rst_pending", commit_pending, 0);
      chk("rst_bank", bank_sel, 0);
    end
    m_bank = 0; m_ptr = 0; m_pend = 0; e_we = 0; e_sw = 0;
    e_addr = '0; e_wdata = '0; d1 = '0; d2 = '0; e_v1 = '0; e_v2 = '0; last_g = '0;
    req_s = '1;
    for (int i = 0; i < N; i++) addr_s[i] = AW'($urandom);
    wr_en = 1'b0;
    commit = 1'b0;
    rd_req = '0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic step();
    logic [N-1:0] eg;
    int gi;
    for (int i = 0; i < N; i++) begin
      if (last_g[i]) begin
        if ($urandom_range(0, 2) == 0) req_s[i] = 1'b0;
        else addr_s[i] = AW'($urandom);
      end
      if (!req_s[i] && $urandom_range(0, 2) == 0) begin
        req_s[i] = 1'b1;
        addr_s[i] = AW'($urandom);
      end
    end
    wr_en = ($urandom_range(0, 3) == 0);
    wr_addr = AW'($urandom);
    wr_data = DW'($urandom);
    commit = ($urandom_range(0, 14) == 0);
    if ($urandom_range(0, 7) == 0) frame_busy = $urandom_range(0, 1) ? '0 : N'($urandom);
    rd_req = req_s;
    for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = addr_s[i];
    @(negedge clk);
    eg = wr_en ? '0 : rr_pick(req_s, m_ptr);
    chk("gnt", rd_gnt, eg);
    chk("we", ram_we, e_we);
    chk("addr", ram_addr, e_addr);
    if (e_we) chk("wdata", ram_wdata, e_wdata);
    chk("bank", bank_sel, m_bank);
    chk("pending", commit_pending, m_pend);
    chk("swapped", swapped, e_sw);
    chk("valid", rd_valid, e_v2);
    if (e_v2 != 0) chk("rdata", rd_data, d2);
    gi = 0;
    for (int i = 0; i < N; i++) if (eg[i]) gi = i;
    e_v2 = e_v1;
    d2 = d1;
    e_v1 = eg;
    d1 = mem[m_bank][addr_s[gi]];
    e_we = wr_en;
    if (wr_en) begin
      mem[1 - m_bank][wr_addr] = wr_data;
      e_addr = {1'(1 - m_bank), wr_addr};
      e_wdata = wr_data;
    end else if (eg != 0) begin
      e_addr = {1'(m_bank), addr_s[gi]};
      m_ptr = (gi + 1) % N;
    end
    e_sw = 0;
    if (!m_pend) m_pend = commit;
    else if (frame_busy == 0 && !wr_en) begin
      m_bank = 1 - m_bank;
      e_sw = 1;
      m_pend = commit;
    end
    last_g = eg;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int a = 0; a < 512; a++) begin
      phys[a] = DW'($urandom);
      mem[a / 256][a % 256] = phys[a];
    end
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    do_reset(4);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset(3);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
